dsp_slice_pipe: RTL and testbench
=================================

DSP_SLICE_PIPE -- requirements
Module: dsp_slice_pipe

Interface
REQ-001 SHALL have parameter DATAINWIDTH, default 18: width of a, b, d and bcout.
REQ-002 SHALL have parameter DATAOUTWIDTH, default 48: width of c, pcin, p and pcout.
REQ-003 SHALL have parameter OPWIDTH, default 8: width of opmode.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 a, b, d  in  DATAINWIDTH  multiplier operand and pre-adder operands.
REQ-007 c, pcin  in  DATAOUTWIDTH  post-adder operand and cascade input.
REQ-008 carryin  in  1  post-adder carry/borrow input.
REQ-009 opmode  in  OPWIDTH  per-beat operation select, sampled with the operands.
REQ-010 in_valid / in_ready  in / out  1  input handshake.
REQ-011 out_valid / out_ready  out / in  1  output handshake.
REQ-012 m  out  2*DATAINWIDTH  stage-2 product register.
REQ-013 p, pcout  out  DATAOUTWIDTH  result register; pcout is identical to p.
REQ-014 carryout, carryoutf  out  1  post-adder carry; carryoutf is identical to carryout.
REQ-015 bcout  out  DATAINWIDTH  stage-1 registered pre-adder result, for cascade.

Function
REQ-016 Three register stages: S1 registers a, d, b, c, pcin, carryin and opmode; S2 registers pre-adder, m and the aligned S1 fields; S3 registers p and carryout.
- Each stage carries a valid bit.
REQ-017 Global advance enable = !(out_valid && !out_ready).
- in_ready SHALL equal the enable.
- A beat is accepted when in_valid && in_ready.
REQ-018 With out_ready held high, an accepted beat SHALL appear with out_valid=1 exactly 3 cycles later, at a throughput of 1 beat per cycle.
REQ-019 When the enable is low, every register including the valid bits SHALL hold.
REQ-020 Pre-adder:
- opmode[4]=0: bsel = b.
- opmode[4]=1, opmode[6]=0: bsel = d + b.
- opmode[4]=1, opmode[6]=1: bsel = d - b.
- Result is modulo 2^DATAINWIDTH and is registered into bcout.
REQ-021 m = a * bsel, unsigned, full 2*DATAINWIDTH width.
REQ-022 X mux on opmode[1:0]:
- 0 = zero.
- 1 = m, zero-extended.
- 2 = p.
- 3 = {d,a,b}, truncated to the low DATAOUTWIDTH bits.
REQ-023 Z mux on opmode[3:2]: 0 = zero, 1 = pcin, 2 = p, 3 = c.
REQ-024 Post-adder:
- opmode[7]=0: {carryout,p} = Z + X + carryin.
- opmode[7]=1: {carryout,p} = Z - (X + carryin).
- carryout = bit DATAOUTWIDTH of the DATAOUTWIDTH+1-bit result.
REQ-025 X=p and Z=p SHALL use the current p register value (accumulate).
REQ-026 p and carryout SHALL update only when the S3 beat is valid and the enable is high.
- Bubbles SHALL NOT modify the accumulator.
REQ-027 out_valid deasserts after a transfer when no valid beat follows.
- p holds its last value after out_valid deasserts.

Reset
REQ-028 rstn low SHALL immediately clear every data register, valid bit, m, p, pcout, bcout, carryout and carryoutf to 0.
REQ-029 In-flight beats SHALL be discarded on reset.
REQ-030 in_ready SHALL read 1 during and after reset, since out_valid=0.
REQ-031 First accept after release SHALL occur on the first rising edge with rstn high and in_valid high.

Structure
REQ-032 A shared package SHALL hold:
- X-mux and Z-mux encodings.
- opmode bit-index constants.
- Default widths.
REQ-033 One sub-module SHALL exist: dsp_preadd_mul, the combinational pre-adder plus multiplier.
- The pipeline, muxes and handshake SHALL reside in the top module.

Verification
REQ-034 Multiply-add: a=15, b=12, d=20, c=32, carryin=1, opmode=8'h1D (preadd add, X=m, Z=c) -> 3 cycles later m=480, p=513, carryout=0.
REQ-035 Pre-subtract: same operands, opmode=8'h5D -> m=120, p=153.
REQ-036 Post-subtract: c=32, carryin=1, opmode=8'h8C (X=0, Z=c, sub) -> p=31; with c=0 -> p=2^48-1, carryout=1.
REQ-037 Accumulate: reset, then three beats a=15, b=12, d=20, carryin=0, opmode=8'h19 (X=m, Z=p) -> p = 480, 960, 1440 on consecutive out_valid cycles.
- An idle gap inserted between the beats leaves the results unchanged.
REQ-038 Backpressure: out_ready=0 for 4 cycles mid-stream -> in_ready=0 and p/out_valid stable throughout; no beat lost or duplicated after out_ready=1.
REQ-039 Reset mid-operation: rstn pulsed low with 2 beats in flight -> all outputs 0 within the same cycle; no out_valid for the discarded beats.

Source files
------------

// File: rtl/dsp_slice_pipe_pkg.sv
// Shared definitions for the DSP slice pipeline: default widths, opmode
// bit positions and the X/Z post-adder operand mux encodings.
package dsp_slice_pipe_pkg;

  localparam int DEF_DATAINWIDTH  = 18;
  localparam int DEF_DATAOUTWIDTH = 48;
  localparam int DEF_OPWIDTH      = 8;

  // opmode field positions
  localparam int OP_XSEL_LSB    = 0;
  localparam int OP_ZSEL_LSB    = 2;
  localparam int OP_PREADD_EN   = 4;
  localparam int OP_PREADD_SUB  = 6;
  localparam int OP_POSTADD_SUB = 7;

  typedef enum logic [1:0] {
    XSEL_ZERO = 2'd0,
    XSEL_M    = 2'd1,
    XSEL_P    = 2'd2,
    XSEL_DAB  = 2'd3
  } xsel_e;

  typedef enum logic [1:0] {
    ZSEL_ZERO = 2'd0,
    ZSEL_PCIN = 2'd1,
    ZSEL_P    = 2'd2,
    ZSEL_C    = 2'd3
  } zsel_e;

endpackage

// File: rtl/dsp_slice_pipe_preadd_mul.sv
// Combinational pre-adder (pass b, d+b or d-b, wrapping) feeding an
// unsigned full-width multiplier.
module dsp_preadd_mul
  import dsp_slice_pipe_pkg::*;
#(
  parameter int DATAINWIDTH = DEF_DATAINWIDTH
) (
  input  logic [DATAINWIDTH-1:0]   a,
  input  logic [DATAINWIDTH-1:0]   b,
  input  logic [DATAINWIDTH-1:0]   d,
  input  logic                     preadd_en,
  input  logic                     preadd_sub,
  output logic [DATAINWIDTH-1:0]   bsel,
  output logic [2*DATAINWIDTH-1:0] prod
);

  // select the multiplier's second operand
  always_comb begin
    bsel = b;
    if (preadd_en) begin
      bsel = preadd_sub ? (d - b) : (d + b);
    end
  end

  assign prod = {{DATAINWIDTH{1'b0}}, a} * {{DATAINWIDTH{1'b0}}, bsel};

endmodule

// File: rtl/dsp_slice_pipe.sv
// Three-stage DSP slice: S1 input registers, S2 pre-adder/multiplier
// registers, S3 post-adder/accumulator. A single advance enable stalls the
// whole pipe while the output beat is held by the consumer.
module dsp_slice_pipe
  import dsp_slice_pipe_pkg::*;
#(
  parameter int DATAINWIDTH  = DEF_DATAINWIDTH,
  parameter int DATAOUTWIDTH = DEF_DATAOUTWIDTH,
  parameter int OPWIDTH      = DEF_OPWIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATAINWIDTH-1:0]    a,
  input  logic [DATAINWIDTH-1:0]    b,
  input  logic [DATAINWIDTH-1:0]    d,
  input  logic [DATAOUTWIDTH-1:0]   c,
  input  logic [DATAOUTWIDTH-1:0]   pcin,
  input  logic                      carryin,
  input  logic [OPWIDTH-1:0]        opmode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATAINWIDTH-1:0]  m,
  output logic [DATAOUTWIDTH-1:0]   p,
  output logic [DATAOUTWIDTH-1:0]   pcout,
  output logic                      carryout,
  output logic                      carryoutf,
  output logic [DATAINWIDTH-1:0]    bcout
);

  logic en;

  // stage 1
  logic [DATAINWIDTH-1:0]  a1, b1, d1;
  logic [DATAOUTWIDTH-1:0] c1, pcin1;
  logic                    cin1;
  logic [OPWIDTH-1:0]      op1;
  logic                    v1;

  // stage 2
  logic [DATAINWIDTH-1:0]  a2, b2, d2;
  logic [DATAOUTWIDTH-1:0] c2, pcin2;
  logic                    cin2;
  logic [OPWIDTH-1:0]      op2;
  logic                    v2;

  // stage 3 valid
  logic                    v3;

  logic [DATAINWIDTH-1:0]   bsel;
  logic [2*DATAINWIDTH-1:0] prod;
  logic [DATAOUTWIDTH-1:0]  xval, zval;
  logic [DATAOUTWIDTH:0]    post;
  logic                     unused_op2;

  assign en        = !(v3 && !out_ready);
  assign in_ready  = en;
  assign out_valid = v3;
  assign pcout     = p;
  assign carryoutf = carryout;

  // Pre-adder selection bits are consumed in S2; the rest travel on for
  // the post-adder, so some high bits of the S2 copy are never read.
  assign unused_op2 = ^op2;

  dsp_preadd_mul #(
    .DATAINWIDTH(DATAINWIDTH)
  ) u_preadd_mul (
    .a          (a1),
    .b          (b1),
    .d          (d1),
    .preadd_en  (op1[OP_PREADD_EN]),
    .preadd_sub (op1[OP_PREADD_SUB]),
    .bsel       (bsel),
    .prod       (prod)
  );

  // S1: capture an accepted beat; data only loads on a real beat
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a1    <= '0;
      b1    <= '0;
      d1    <= '0;
      c1    <= '0;
      pcin1 <= '0;
      cin1  <= 1'b0;
      op1   <= '0;
      v1    <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1    <= a;
        b1    <= b;
        d1    <= d;
        c1    <= c;
        pcin1 <= pcin;
        cin1  <= carryin;
        op1   <= opmode;
      end
    end
  end

  // S2: register pre-adder result, product and the aligned S1 fields
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a2    <= '0;
      b2    <= '0;
      d2    <= '0;
      c2    <= '0;
      pcin2 <= '0;
      cin2  <= 1'b0;
      op2   <= '0;
      v2    <= 1'b0;
      bcout <= '0;
      m     <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        a2    <= a1;
        b2    <= b1;
        d2    <= d1;
        c2    <= c1;
        pcin2 <= pcin1;
        cin2  <= cin1;
        op2   <= op1;
        bcout <= bsel;
        m     <= prod;
      end
    end
  end

  // X operand mux
  always_comb begin
    xval = '0;
    case (xsel_e'(op2[OP_XSEL_LSB +: 2]))
      XSEL_ZERO: xval = '0;
      XSEL_M:    xval = DATAOUTWIDTH'(m);
      XSEL_P:    xval = p;
      XSEL_DAB:  xval = DATAOUTWIDTH'({d2, a2, b2});
      default:   xval = '0;
    endcase
  end

  // Z operand mux
  always_comb begin
    zval = '0;
    case (zsel_e'(op2[OP_ZSEL_LSB +: 2]))
      ZSEL_ZERO: zval = '0;
      ZSEL_PCIN: zval = pcin2;
      ZSEL_P:    zval = p;
      ZSEL_C:    zval = c2;
      default:   zval = '0;
    endcase
  end

  // post-adder with carry out in the extra top bit (borrow when subtracting)
  always_comb begin
    if (op2[OP_POSTADD_SUB]) begin
      post = {1'b0, zval} - ({1'b0, xval} + {{DATAOUTWIDTH{1'b0}}, cin2});
    end else begin
      post = {1'b0, zval} + {1'b0, xval} + {{DATAOUTWIDTH{1'b0}}, cin2};
    end
  end

  // S3: result/accumulator only moves on a valid beat, bubbles leave it alone
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3       <= 1'b0;
      p        <= '0;
      carryout <= 1'b0;
    end else if (en) begin
      v3 <= v2;
      if (v2) begin
        p        <= post[DATAOUTWIDTH-1:0];
        carryout <= post[DATAOUTWIDTH];
      end
    end
  end

endmodule

// File: tb/tb_dsp_slice_pipe.sv
// Self-checking bench for dsp_slice_pipe: directed spec examples plus a
// randomized stream against an arithmetic reference model.
module tb_dsp_slice_pipe;

  localparam int DIN  = 18;
  localparam int DOUT = 48;
  localparam int OPW  = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DIN-1:0]    a, b, d;
  logic [DOUT-1:0]   c, pcin;
  logic              carryin;
  logic [OPW-1:0]    opmode;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [2*DIN-1:0]  m;
  logic [DOUT-1:0]   p, pcout;
  logic              carryout, carryoutf;
  logic [DIN-1:0]    bcout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DOUT-1:0] model_acc = '0;

  dsp_slice_pipe #(
    .DATAINWIDTH(DIN), .DATAOUTWIDTH(DOUT), .OPWIDTH(OPW)
  ) dut (
    .clk(clk), .rstn(rstn), .a(a), .b(b), .d(d), .c(c), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .m(m), .p(p), .pcout(pcout), .carryout(carryout),
    .carryoutf(carryoutf), .bcout(bcout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: spec arithmetic on plain integers
  function automatic void model(input logic [DIN-1:0] ia, ib, id,
                                input logic [DOUT-1:0] ic, ipc,
                                input logic icin, input logic [7:0] iop,
                                input logic [DOUT-1:0] acc,
                                output logic [2*DIN-1:0] em,
                                output logic [DOUT-1:0] ep,
                                output logic eco);
    logic [DIN-1:0]   bs;
    logic [2*DIN-1:0] aw, bw;
    logic [3*DIN-1:0] dab;
    logic [DOUT-1:0]  x, z;
    logic [DOUT:0]    r;
    if (!iop[4])     bs = ib;
    else if (iop[6]) bs = id - ib;
    else             bs = id + ib;
    aw = {{DIN{1'b0}}, ia};
    bw = {{DIN{1'b0}}, bs};
    em = aw * bw;
    dab = {id, ia, ib};
    case (iop[1:0])
      2'd0: x = '0;
      2'd1: x = {{(DOUT-2*DIN){1'b0}}, em};
      2'd2: x = acc;
      default: x = dab[DOUT-1:0];
    endcase
    case (iop[3:2])
      2'd0: z = '0;
      2'd1: z = ipc;
      2'd2: z = acc;
      default: z = ic;
    endcase
    if (iop[7]) r = {1'b0, z} - {1'b0, x} - {{DOUT{1'b0}}, icin};
    else        r = {1'b0, z} + {1'b0, x} + {{DOUT{1'b0}}, icin};
    ep  = r[DOUT-1:0];
    eco = r[DOUT];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    model_acc = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    a = '0; b = '0; d = '0; c = '0; pcin = '0; carryin = 1'b0; opmode = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #3;
    n_checks++;
    if ({m, p, pcout, bcout, carryout, carryoutf, out_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: m=%0d p=%0d pcout=%0d bcout=%0d co=%b cof=%b ov=%b expected all 0",
               m, p, pcout, bcout, carryout, carryoutf, out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_acc = '0;
  endtask

  task automatic send_one(input string name, input logic [DIN-1:0] ia, ib, id,
                          input logic [DOUT-1:0] ic, input logic icin,
                          input logic [7:0] iop, input logic [2*DIN-1:0] em,
                          input logic [DOUT-1:0] ep, input logic eco);
    int n;
    @(negedge clk);
    a = ia; b = ib; d = id; c = ic; pcin = '0; carryin = icin; opmode = iop;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready=%b expected 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid after %0d cycles expected 3", name, n);
    end
    n_checks++;
    if (m !== em) begin
      n_fail++;
      $display("FAIL %s_m: got %0d expected %0d", name, m, em);
    end
    n_checks++;
    if (p !== ep || pcout !== ep) begin
      n_fail++;
      $display("FAIL %s_p: p=%0d pcout=%0d expected %0d", name, p, pcout, ep);
    end
    n_checks++;
    if (carryout !== eco || carryoutf !== eco) begin
      n_fail++;
      $display("FAIL %s_carry: co=%b cof=%b expected %b", name, carryout, carryoutf, eco);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || p !== ep) begin
      n_fail++;
      $display("FAIL %s_after: out_valid=%b p=%0d expected 0 and %0d", name, out_valid, p, ep);
    end
  endtask

  task automatic test_muladd();
    do_reset();
    send_one("muladd", 18'd15, 18'd12, 18'd20, 48'd32, 1'b1, 8'h1D, 36'd480, 48'd513, 1'b0);
    send_one("presub", 18'd15, 18'd12, 18'd20, 48'd32, 1'b1, 8'h5D, 36'd120, 48'd153, 1'b0);
  endtask

  task automatic test_postsub();
    do_reset();
    send_one("postsub", 18'd15, 18'd12, 18'd20, 48'd32, 1'b1, 8'h8C, 36'd180, 48'd31, 1'b0);
    send_one("postsub_wrap", 18'd15, 18'd12, 18'd20, 48'd0, 1'b1, 8'h8C, 36'd180,
             48'hFFFF_FFFF_FFFF, 1'b1);
  endtask

  task automatic test_accumulate(input int gap);
    logic [DOUT-1:0] got [3];
    int gc [3];
    int k;
    do_reset();
    k = 0;
    out_ready = 1'b1;
    a = 18'd15; b = 18'd12; d = 18'd20; c = '0; pcin = '0; carryin = 1'b0; opmode = 8'h19;
    for (int cyc = 0; cyc < 3 * (gap + 1) + 8; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (k < 3) begin
          got[k] = p;
          gc[k] = cyc;
        end
        k++;
      end
      in_valid = ((cyc % (gap + 1)) == 0) && ((cyc / (gap + 1)) < 3);
    end
    in_valid = 1'b0;
    n_checks++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL acc_gap%0d_count: %0d results expected 3", gap, k);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== 48'(480 * (i + 1))) begin
          n_fail++;
          $display("FAIL acc_gap%0d_p%0d: got %0d expected %0d", gap, i, got[i], 480 * (i + 1));
        end
      end
      n_checks++;
      if (gc[2] - gc[0] !== 2 * (gap + 1)) begin
        n_fail++;
        $display("FAIL acc_gap%0d_spacing: %0d cycles expected %0d", gap, gc[2] - gc[0], 2 * (gap + 1));
      end
    end
  endtask

  // mode 0: random in_valid/out_ready; mode 1: full rate with a 4-cycle stall
  task automatic run_stream(input string name, input int nbeats, input int mode);
    logic [DOUT:0] q[$];
    logic [DOUT:0] ex;
    logic [2*DIN-1:0] em;
    logic [DOUT-1:0] ep, p_prev;
    logic eco, stall_prev;
    int accepted, cyc, guard;
    do_reset();
    accepted = 0; cyc = 0; stall_prev = 1'b0; p_prev = '0;
    while (accepted < nbeats && cyc < 3000) begin
      @(negedge clk);
      if (stall_prev) begin
        n_checks++;
        if (p !== p_prev || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_stall_hold: p=%0d ov=%b expected p=%0d ov=1", name, p, out_valid, p_prev);
        end
      end
      a = DIN'($urandom()); b = DIN'($urandom()); d = DIN'($urandom());
      c = DOUT'({$urandom(), $urandom()}); pcin = DOUT'({$urandom(), $urandom()});
      carryin = 1'($urandom()); opmode = OPW'($urandom());
      if (mode == 1) begin
        in_valid = 1'b1;
        out_ready = !(cyc >= 6 && cyc < 10);
      end else begin
        in_valid = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++;
        $display("FAIL %s_in_ready: got %b with ov=%b ordy=%b", name, in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_spurious: out_valid with no pending beat p=%0d", name, p);
        end else begin
          ex = q.pop_front();
          if (p !== ex[DOUT-1:0] || pcout !== ex[DOUT-1:0] || carryout !== ex[DOUT]) begin
            n_fail++;
            $display("FAIL %s_result: p=%h co=%b expected p=%h co=%b", name, p, carryout,
                     ex[DOUT-1:0], ex[DOUT]);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(a, b, d, c, pcin, carryin, opmode, model_acc, em, ep, eco);
        model_acc = ep;
        q.push_back({eco, ep});
        accepted++;
      end
      stall_prev = out_valid && !out_ready;
      p_prev = p;
      cyc++;
    end
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        n_checks++;
        ex = q.pop_front();
        if (p !== ex[DOUT-1:0] || carryout !== ex[DOUT]) begin
          n_fail++;
          $display("FAIL %s_drain: p=%h co=%b expected p=%h co=%b", name, p, carryout,
                   ex[DOUT-1:0], ex[DOUT]);
        end
      end
      guard++;
    end
    n_checks++;
    if (q.size() != 0 || accepted != nbeats) begin
      n_fail++;
      $display("FAIL %s_lost: %0d beats never output, %0d of %0d accepted", name, q.size(),
               accepted, nbeats);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_extra: out_valid=%b after drain expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    do_reset();
    a = 18'd15; b = 18'd12; d = 18'd20; c = 48'd32; pcin = '0; carryin = 1'b1; opmode = 8'h1D;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({m, p, pcout, bcout, carryout, carryoutf, out_valid} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_clear: m=%0d p=%0d bcout=%0d co=%b ov=%b rdy=%b expected 0s and rdy=1",
               m, p, bcout, carryout, out_valid, in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    model_acc = '0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset_discard: %0d out_valid cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_muladd();
    test_postsub();
    test_accumulate(0);
    test_accumulate(2);
    run_stream("backpressure", 12, 1);
    run_stream("random", 200, 0);
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
